// File: rtl/motor_cmd_sender.sv
// motor_cmd_sender
//   Serialises motor commands and status polls onto a byte UART transmitter
//   and collects the 4-byte status response.
//
//   Command packet: b0 = {4'h0, motor}, b1..b5 = 40-bit word W, LSB byte first,
//   with W = {5'b0, dir, steps[14:0], divider[14:0], 4'h0}.
//   Poll: single byte 8'h0F, then four tagged response bytes {tag[1:0], 0, data[4:0]}.
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
//   cmd_ready are both high; cmd_ready is high only while the FSM is IDLE,
//   and the fields are captured at that edge.
//
// Ports:
//   CLK_SE_AR, rst            clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_motor/divider/steps/dir  command fields
//   poll_req                  status poll request pulse
//   tx_start/tx_data/tx_busy  byte transmitter interface
//   rx_valid/rx_data          received byte interface
//   status_pending/term/valid status from the last good poll
//   status_error              poll timeout or bad response byte
//   cmd_drop                  accepted command with motor index > 9
//   busy                      FSM not in IDLE
module motor_cmd_sender #(
    parameter int unsigned GAP_CYCLES   = 4095,
    parameter int unsigned RESP_TIMEOUT = 262143
) (
    input  logic        CLK_SE_AR,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_motor,
    input  logic [14:0] cmd_divider,
    input  logic [14:0] cmd_steps,
    input  logic        cmd_dir,
    input  logic        poll_req,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [9:0]  status_pending,
    output logic [9:0]  status_term,
    output logic        status_valid,
    output logic        status_error,
    output logic        cmd_drop,
    output logic        busy
);

    localparam int unsigned    TW        = $clog2(RESP_TIMEOUT + 1);
    localparam logic [15:0]    GAP_LOAD  = 16'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]  TO_LOAD   = TW'(RESP_TIMEOUT);
    localparam logic [7:0]     POLL_BYTE = 8'h0F;

    typedef enum logic [1:0] {IDLE, SEND, GAP, RESP_WAIT} stateType;

    stateType      state, stateNext;
    logic [47:0]   pktBuf;
    logic [2:0]    bytesLeft;
    logic          isPoll;
    logic [15:0]   gapCnt;
    logic [TW-1:0] respCnt;
    logic [1:0]    tagK;
    logic [4:0]    slot0, slot1, slot2;
    logic          pollPending;

    logic          acceptCmd, dropCmd, takePoll, sendByte;
    logic          enterResp, rxGood, rxBad, respTimeout;
    logic [39:0]   cmdWord;

    assign cmdWord   = {5'b0, cmd_dir, cmd_steps, cmd_divider, 4'h0};
    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge CLK_SE_AR or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext   = state;
        acceptCmd   = 1'b0;
        dropCmd     = 1'b0;
        takePoll    = 1'b0;
        sendByte    = 1'b0;
        enterResp   = 1'b0;
        rxGood      = 1'b0;
        rxBad       = 1'b0;
        respTimeout = 1'b0;
        case (state)
            IDLE: begin
                // Commands win over polls; a skipped poll stays pending.
                if (cmd_valid) begin
                    acceptCmd = 1'b1;
                    if (cmd_motor > 4'd9) dropCmd = 1'b1;
                    else                  stateNext = SEND;
                end else if (poll_req || pollPending) begin
                    takePoll  = 1'b1;
                    stateNext = SEND;
                end
            end
            SEND: begin
                if (!tx_busy) begin
                    sendByte  = 1'b1;
                    stateNext = GAP;
                end
            end
            GAP: begin
                if (gapCnt == 16'd0) begin
                    if (bytesLeft != 3'd0) stateNext = SEND;
                    else if (isPoll) begin
                        stateNext = RESP_WAIT;
                        enterResp = 1'b1;
                    end else stateNext = IDLE;
                end
            end
            RESP_WAIT: begin
                if (rx_valid) begin
                    if (rx_data[7:6] == tagK && !rx_data[5]) begin
                        rxGood = 1'b1;
                        if (tagK == 2'd3) stateNext = IDLE;
                    end else begin
                        rxBad     = 1'b1;
                        stateNext = IDLE;
                    end
                end else if (respCnt <= TW'(1)) begin
                    // The decrement at this edge would take the counter to zero.
                    respTimeout = 1'b1;
                    stateNext   = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge CLK_SE_AR or posedge rst) begin
        if (rst) begin
            tx_start       <= 1'b0;
            tx_data        <= 8'h00;
            cmd_drop       <= 1'b0;
            status_valid   <= 1'b0;
            status_error   <= 1'b0;
            status_pending <= 10'd0;
            status_term    <= 10'd0;
            pollPending    <= 1'b0;
            pktBuf         <= 48'd0;
            bytesLeft      <= 3'd0;
            isPoll         <= 1'b0;
            gapCnt         <= 16'd0;
            respCnt        <= '0;
            tagK           <= 2'd0;
            slot0          <= 5'd0;
            slot1          <= 5'd0;
            slot2          <= 5'd0;
        end else begin
            tx_start     <= sendByte;
            cmd_drop     <= dropCmd;
            status_valid <= 1'b0;
            status_error <= rxBad | respTimeout;
            pollPending  <= (pollPending | poll_req) & ~takePoll;

            // Packet is a shift register drained LSB byte first.
            if (acceptCmd && !dropCmd) begin
                pktBuf    <= {cmdWord, 4'h0, cmd_motor};
                bytesLeft <= 3'd6;
                isPoll    <= 1'b0;
            end else if (takePoll) begin
                pktBuf    <= {40'd0, POLL_BYTE};
                bytesLeft <= 3'd1;
                isPoll    <= 1'b1;
            end else if (sendByte) begin
                tx_data   <= pktBuf[7:0];
                pktBuf    <= {8'h00, pktBuf[47:8]};
                bytesLeft <= bytesLeft - 3'd1;
            end

            if (sendByte)                               gapCnt <= GAP_LOAD;
            else if (state == GAP && gapCnt != 16'd0)   gapCnt <= gapCnt - 16'd1;

            if (enterResp) begin
                respCnt <= TO_LOAD;
                tagK    <= 2'd0;
            end else if (rxGood) begin
                respCnt <= TO_LOAD;
                tagK    <= tagK + 2'd1;
                case (tagK)
                    2'd0: slot0 <= rx_data[4:0];
                    2'd1: slot1 <= rx_data[4:0];
                    2'd2: slot2 <= rx_data[4:0];
                    2'd3: begin
                        status_pending <= {slot1, slot0};
                        status_term    <= {rx_data[4:0], slot2};
                        status_valid   <= 1'b1;
                    end
                endcase
            end else if (rxBad || respTimeout) begin
                tagK  <= 2'd0;
                slot0 <= 5'd0;
                slot1 <= 5'd0;
                slot2 <= 5'd0;
            end else if (state == RESP_WAIT) begin
                respCnt <= respCnt - TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_sender.sv
module tb_motor_cmd_sender;
  localparam int G = 4;
  localparam int T = 20;

  logic        CLK_SE_AR = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [3:0]  cmd_motor = 4'd0;
  logic [14:0] cmd_divider = 15'd0;
  logic [14:0] cmd_steps = 15'd0;
  logic        cmd_dir = 1'b0;
  logic        poll_req = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic [9:0]  status_pending;
  logic [9:0]  status_term;
  logic        status_valid;
  logic        status_error;
  logic        cmd_drop;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int consec = 0;
  logic prev_start = 1'b0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         stamp_q[$];

  motor_cmd_sender #(.GAP_CYCLES(G), .RESP_TIMEOUT(T)) dut (
    .CLK_SE_AR(CLK_SE_AR), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_motor(cmd_motor), .cmd_divider(cmd_divider),
    .cmd_steps(cmd_steps), .cmd_dir(cmd_dir),
    .poll_req(poll_req),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .rx_valid(rx_valid), .rx_data(rx_data),
    .status_pending(status_pending), .status_term(status_term),
    .status_valid(status_valid), .status_error(status_error),
    .cmd_drop(cmd_drop), .busy(busy)
  );

  // clock / cycle counter
  always #5 CLK_SE_AR = ~CLK_SE_AR;
  always @(posedge CLK_SE_AR) cyc <= cyc + 1;

  // transmit monitor
  always @(negedge CLK_SE_AR) begin
    if (tx_start) begin
      got_q.push_back(tx_data);
      stamp_q.push_back(cyc);
    end
    if (tx_start && prev_start) consec++;
    prev_start = tx_start;
  end

  task automatic tick();
    @(negedge CLK_SE_AR);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tx(input int n, input int budget, input string tag);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk(tag, got_q.size(), n);
  endtask

  // compare captured bytes with the scoreboard, then clear both
  task automatic compare_tx(input string tag);
    int n = exp_q.size();
    chk({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size()) chk({tag, "_byte"}, got_q[i], exp_q[i]);
      if (i > 0 && i < stamp_q.size())
        chk({tag, "_spacing"}, (stamp_q[i] - stamp_q[i-1]) >= G, 1);
    end
    exp_q.delete();
    got_q.delete();
    stamp_q.delete();
  endtask

  task automatic send_cmd(input logic [3:0] m, input logic [14:0] d, input logic [14:0] s,
                          input logic dir, input logic with_poll);
    cmd_valid = 1'b1;
    cmd_motor = m;
    cmd_divider = d;
    cmd_steps = s;
    cmd_dir = dir;
    poll_req = with_poll;
    tick();
    cmd_valid = 1'b0;
    poll_req = 1'b0;
    cmd_motor = 4'hF;
    cmd_divider = 15'h5A5A;
    cmd_steps = 15'h2BCD;
    cmd_dir = ~dir;
  endtask

  task automatic pulse_poll();
    poll_req = 1'b1;
    tick();
    poll_req = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  initial begin
    // reset state
    tick();
    tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_pending", status_pending, 10'h000);
    chk("rst_term", status_term, 10'h000);
    chk("rst_strobes", {status_valid, status_error, cmd_drop}, 3'b000);
    rst = 1'b0;
    tick();

    // command packet, transmitter busy for a while first
    tx_busy = 1'b1;
    send_cmd(4'd3, 15'h0100, 15'h0005, 1'b1, 1'b0);
    chk("cmd_busy", busy, 1);
    chk("cmd_ready_low", cmd_ready, 0);
    repeat (4) tick();
    chk("tx_held_by_busy", got_q.size(), 0);
    tx_busy = 1'b0;
    exp_q = '{8'h03, 8'h00, 8'h10, 8'h28, 8'h00, 8'h04};
    wait_tx(6, 200, "cmd_wait");
    repeat (G + 2) tick();
    chk("cmd_idle", busy, 0);
    compare_tx("cmd1");

    // rx outside the response window is ignored
    send_rx(8'h05);
    chk("rx_idle_ignored", {busy, status_valid, status_error}, 3'b000);

    // good poll
    pulse_poll();
    wait_tx(1, 50, "poll1_wait");
    repeat (G) tick();
    send_rx(8'h05);
    send_rx(8'h5F);
    send_rx(8'h80);
    send_rx(8'hD1);
    chk("poll1_valid", status_valid, 1);
    chk("poll1_pending", status_pending, 10'h3E5);
    chk("poll1_term", status_term, 10'h220);
    tick();
    chk("poll1_valid_pulse", status_valid, 0);
    chk("poll1_idle", busy, 0);
    exp_q = '{8'h0F};
    compare_tx("poll1");

    // out-of-sequence response byte
    pulse_poll();
    wait_tx(1, 50, "poll2_wait");
    repeat (G) tick();
    send_rx(8'h05);
    send_rx(8'h80);
    chk("poll2_error", status_error, 1);
    chk("poll2_valid", status_valid, 0);
    chk("poll2_pending_kept", status_pending, 10'h3E5);
    chk("poll2_term_kept", status_term, 10'h220);
    chk("poll2_idle", busy, 0);
    tick();
    chk("poll2_error_pulse", status_error, 0);
    exp_q = '{8'h0F};
    compare_tx("poll2");

    // no response: error exactly T cycles after entering the wait
    pulse_poll();
    wait_tx(1, 50, "poll3_wait");
    repeat (G + T - 1) tick();
    chk("timeout_early", status_error, 0);
    tick();
    chk("timeout_error", status_error, 1);
    chk("timeout_pending_kept", status_pending, 10'h3E5);
    tick();
    chk("timeout_error_pulse", status_error, 0);
    chk("timeout_idle", busy, 0);
    exp_q = '{8'h0F};
    compare_tx("poll3");

    // dropped command
    send_cmd(4'd12, 15'h0001, 15'h0001, 1'b0, 1'b0);
    chk("drop_pulse", cmd_drop, 1);
    chk("drop_idle", busy, 0);
    tick();
    chk("drop_pulse_end", cmd_drop, 0);
    repeat (10) tick();
    chk("drop_no_tx", got_q.size(), 0);

    // command with simultaneous poll, plus two merged polls during the packet
    send_cmd(4'd1, 15'h7FFF, 15'h0000, 1'b0, 1'b1);
    repeat (3) tick();
    pulse_poll();
    repeat (5) tick();
    pulse_poll();
    exp_q = '{8'h01, 8'hF0, 8'hFF, 8'h07, 8'h00, 8'h00, 8'h0F};
    wait_tx(7, 300, "merge_wait");
    repeat (G + T + 10) tick();
    chk("merge_idle", busy, 0);
    compare_tx("merge");

    // reset in the middle of a packet
    send_cmd(4'd2, 15'h1234, 15'h0567, 1'b1, 1'b0);
    wait_tx(3, 200, "rst_mid_wait");
    rst = 1'b1;
    #1;
    chk("rst_mid_tx_start", tx_start, 0);
    chk("rst_mid_tx_data", tx_data, 8'h00);
    chk("rst_mid_ready", cmd_ready, 1);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_status", {status_pending, status_term}, 20'd0);
    tick();
    tick();
    rst = 1'b0;
    repeat (8 * (G + 2)) tick();
    chk("rst_mid_no_more_tx", got_q.size(), 3);
    got_q.delete();
    stamp_q.delete();

    // fresh request after reset
    pulse_poll();
    exp_q = '{8'h0F};
    wait_tx(1, 50, "post_rst_wait");
    compare_tx("post_rst");
    repeat (G + T + 4) tick();

    chk("no_back_to_back_start", consec, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
